ram_arbiter: RTL and testbench

- Shares one synchronous single-port RAM (1-cycle read latency, read-before-write on same address) between two requesters, e.g. instruction fetch (port 0) and load/store or DMA (port 1).
- Round-robin arbitration, per-port valid/grant handshake, read-data return tagged to the issuing port.
- A lock input lets a port keep exclusive access for atomic read-modify-write sequences.
- Sits between requesters and the RAM; drives the RAM's we/addr/data_in and consumes its data_out.

---
 rtl/ram_arbiter.sv | 107 ++++++++++
 tb/tb_ram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency single-port RAM between two requesters, with lock for atomic RMW.
// Grants are combinational from req/lock; read data returns the cycle after grant; a requester holds req until granted.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic                  lock0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_t;

    lock_state_t state_q, state_d;
    logic        prio_q, prio_d;
    logic        last_q, last_d;
    logic        tag_rd_q, tag_rd_d;
    logic        tag_port_q, tag_port_d;

    logic        lock_hold;
    logic        cand0, cand1;
    logic        sel1;

    always_comb begin
        // The owner releases the lock in the very cycle its lock input drops.
        lock_hold = ((state_q == LOCKED0) && lock0) || ((state_q == LOCKED1) && lock1);

        cand0 = req0 && !rst && !(lock_hold && (state_q == LOCKED1));
        cand1 = req1 && !rst && !(lock_hold && (state_q == LOCKED0));

        gnt0 = cand0 && (!cand1 || !prio_q);
        gnt1 = cand1 && (!cand0 || prio_q);

        sel1      = gnt1 || (!gnt0 && last_q);
        ram_addr  = sel1 ? addr1 : addr0;
        ram_wdata = sel1 ? wdata1 : wdata0;
        ram_we    = (gnt0 && we0) || (gnt1 && we1);

        prio_d = prio_q;
        last_d = last_q;
        if (gnt0) begin
            prio_d = 1'b1;
            last_d = 1'b0;
        end else if (gnt1) begin
            prio_d = 1'b0;
            last_d = 1'b1;
        end

        tag_rd_d   = (gnt0 && !we0) || (gnt1 && !we1);
        tag_port_d = gnt1;

        state_d = UNLOCKED;
        if (gnt0 && lock0) begin
            state_d = LOCKED0;
        end else if (gnt1 && lock1) begin
            state_d = LOCKED1;
        end else if (lock_hold) begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            prio_q     <= 1'b0;
            last_q     <= 1'b0;
            tag_rd_q   <= 1'b0;
            tag_port_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            last_q     <= last_d;
            tag_rd_q   <= tag_rd_d;
            tag_port_q <= tag_port_d;
        end
    end

    // Gating with rst drops a read that was in flight when reset arrived.
    assign rvalid0 = tag_rd_q && !tag_port_q && !rst;
    assign rvalid1 = tag_rd_q && tag_port_q && !rst;
    assign rdata0  = ram_rdata;
    assign rdata1  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, per-cycle reference model and directed literal checks.
module tb_ram_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM, read-before-write, preloaded with addr[7:0]^0x5A.
    initial begin : ram_model
        logic [DW-1:0] ram_mem [0:65535];
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(posedge clk);
            ram_rdata <= ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] = ram_wdata;
        end
    end

    // Reference model: priority/owner bookkeeping plus its own memory image.
    initial begin : ref_model
        logic [DW-1:0] mem [0:65535];
        int            prio, owner, last, w;
        bit            pend_vld;
        int            pend_port;
        logic [DW-1:0] pend_data;
        bit            rq [2];
        bit            wr [2];
        bit            lk [2];
        bit            el [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        prio = 0; owner = -1; last = 0; pend_vld = 0; pend_port = 0; pend_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_b("mdl_rst_gnt0", gnt0, 1'b0);
                chk_b("mdl_rst_gnt1", gnt1, 1'b0);
                chk_b("mdl_rst_we", ram_we, 1'b0);
                chk_b("mdl_rst_rv0", rvalid0, 1'b0);
                chk_b("mdl_rst_rv1", rvalid1, 1'b0);
                prio = 0; owner = -1; last = 0; pend_vld = 0;
            end else begin
                rq[0] = req0; wr[0] = we0; lk[0] = lock0; ad[0] = addr0; wd[0] = wdata0;
                rq[1] = req1; wr[1] = we1; lk[1] = lock1; ad[1] = addr1; wd[1] = wdata1;
                chk_b("mdl_rv0", rvalid0, pend_vld && pend_port == 0);
                chk_b("mdl_rv1", rvalid1, pend_vld && pend_port == 1);
                if (pend_vld && pend_port == 0) chk_d("mdl_rdata0", rdata0, pend_data);
                if (pend_vld && pend_port == 1) chk_d("mdl_rdata1", rdata1, pend_data);
                if (owner >= 0 && !lk[owner]) owner = -1;
                for (int p = 0; p < 2; p++) el[p] = rq[p] && (owner < 0 || owner == p);
                if (el[0] && el[1]) w = prio;
                else if (el[0])     w = 0;
                else if (el[1])     w = 1;
                else                w = -1;
                chk_b("mdl_gnt0", gnt0, w == 0);
                chk_b("mdl_gnt1", gnt1, w == 1);
                chk_b("mdl_ram_we", ram_we, w >= 0 && wr[(w >= 0) ? w : 0]);
                chk_a("mdl_ram_addr", ram_addr, ad[(w >= 0) ? w : last]);
                chk_d("mdl_ram_wdata", ram_wdata, wd[(w >= 0) ? w : last]);
                pend_vld = 0;
                if (w >= 0) begin
                    pend_vld  = !wr[w];
                    pend_port = w;
                    pend_data = mem[ad[w]];
                    if (wr[w]) mem[ad[w]] = wd[w];
                    if (lk[w]) owner = w;
                    prio = 1 - w;
                    last = w;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; lock0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int c = 0; c < 2; c++) begin
            smp();
            chk_b("rst_gnt0", gnt0, 1'b0);
            chk_b("rst_gnt1", gnt1, 1'b0);
            chk_b("rst_ram_we", ram_we, 1'b0);
            chk_b("rst_rv0", rvalid0, 1'b0);
            chk_b("rst_rv1", rvalid1, 1'b0);
            nxt();
        end

        // Write 0xA5 to 0x1234 then read it back on port 0.
        rst = 1'b0; req1 = 1'b0; we1 = 1'b0;
        addr0 = 16'h1234; wdata0 = 8'hA5;
        smp();
        chk_b("t1_wr_gnt0", gnt0, 1'b1);
        chk_b("t1_wr_we", ram_we, 1'b1);
        chk_a("t1_wr_addr", ram_addr, 16'h1234);
        chk_d("t1_wr_data", ram_wdata, 8'hA5);
        nxt();
        we0 = 1'b0;
        smp();
        chk_b("t1_rd_gnt0", gnt0, 1'b1);
        chk_b("t1_rd_we", ram_we, 1'b0);
        chk_b("t1_wr_no_rv0", rvalid0, 1'b0);
        nxt();
        req0 = 1'b0;
        smp();
        chk_b("t1_rv0", rvalid0, 1'b1);
        chk_d("t1_rdata0", rdata0, 8'hA5);
        chk_b("t1_rv1", rvalid1, 1'b0);
        nxt();
        smp();
        chk_b("t1_rv0_once", rvalid0, 1'b0);
        nxt();

        // Contention after reset: grants alternate starting with port 0.
        rst = 1'b1;
        smp();
        nxt();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0030;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk_b("t2_gnt0", gnt0, (k % 2) == 0);
            chk_b("t2_gnt1", gnt1, (k % 2) == 1);
            if (k > 0) begin
                chk_b("t2_rv0", rvalid0, (k % 2) == 1);
                chk_b("t2_rv1", rvalid1, (k % 2) == 0);
                chk_d("t2_rdata", rdata0, ((k % 2) == 1) ? 8'h7A : 8'h6A);
            end
            nxt();
        end
        req0 = 1'b0; req1 = 1'b0;
        smp();
        chk_b("t2_last_rv1", rvalid1, 1'b1);
        chk_d("t2_last_rdata1", rdata1, 8'h6A);
        chk_b("t2_last_rv0", rvalid0, 1'b0);
        nxt();

        // Port 1 locks for a read-modify-write while port 0 waits.
        req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 16'h0040;
        smp();
        chk_b("t3_l0_gnt1", gnt1, 1'b1);
        nxt();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        we1 = 1'b1; wdata1 = 8'hC3;
        smp();
        chk_b("t3_l1_gnt0", gnt0, 1'b0);
        chk_b("t3_l1_gnt1", gnt1, 1'b1);
        chk_b("t3_l1_rv1", rvalid1, 1'b1);
        chk_d("t3_l1_rdata1", rdata1, 8'h1A);
        nxt();
        req1 = 1'b0;
        smp();
        chk_b("t3_l2_gnt0", gnt0, 1'b0);
        chk_b("t3_l2_gnt1", gnt1, 1'b0);
        nxt();
        lock1 = 1'b0;
        smp();
        chk_b("t3_l3_gnt0", gnt0, 1'b1);
        nxt();
        req0 = 1'b0;
        smp();
        chk_b("t3_rv0", rvalid0, 1'b1);
        chk_d("t3_rdata0", rdata0, 8'hC3);
        nxt();

        // Port 0 writes, port 1 reads the same address the next cycle.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 8'h3C;
        smp();
        chk_b("t4_gnt0", gnt0, 1'b1);
        nxt();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
        smp();
        chk_b("t4_gnt1", gnt1, 1'b1);
        chk_b("t4_n1_rv0", rvalid0, 1'b0);
        chk_b("t4_n1_rv1", rvalid1, 1'b0);
        nxt();
        req1 = 1'b0;
        smp();
        chk_b("t4_rv1", rvalid1, 1'b1);
        chk_d("t4_rdata1", rdata1, 8'h3C);
        nxt();

        // Reset lands while a read is in flight.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
        smp();
        chk_b("t5_gnt0", gnt0, 1'b1);
        nxt();
        rst = 1'b1; we0 = 1'b1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0060;
        smp();
        chk_b("t5_rst_rv0", rvalid0, 1'b0);
        chk_b("t5_rst_gnt0", gnt0, 1'b0);
        chk_b("t5_rst_gnt1", gnt1, 1'b0);
        chk_b("t5_rst_we", ram_we, 1'b0);
        nxt();
        rst = 1'b0; we0 = 1'b0; addr0 = 16'h0050; we1 = 1'b0;
        smp();
        chk_b("t5_prio_gnt0", gnt0, 1'b1);
        chk_b("t5_prio_gnt1", gnt1, 1'b0);
        chk_b("t5_post_rv0", rvalid0, 1'b0);
        nxt();
        req0 = 1'b0; req1 = 1'b0;
        smp();
        chk_b("t5_rv0", rvalid0, 1'b1);
        chk_d("t5_rdata0", rdata0, 8'h0A);
        nxt();

        // Idle: nothing moves.
        for (int c = 0; c < 10; c++) begin
            smp();
            chk_b("t6_gnt0", gnt0, 1'b0);
            chk_b("t6_gnt1", gnt1, 1'b0);
            chk_b("t6_we", ram_we, 1'b0);
            chk_b("t6_rv0", rvalid0, 1'b0);
            chk_b("t6_rv1", rvalid1, 1'b0);
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
